// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/step/halt sequencer for a single-cycle core. It turns the board clock
//   into one-cycle processor clock-enable pulses, driven by two debounced
//   active-low push-buttons (run/halt and step). It also provides a
//   programmable run rate, a PC breakpoint and a post-reset hold.
//
// Ports
//   clk          system clock
//   reset_in     asynchronous active-low reset
//   i_div        run-mode period minus 1 (0 = enable every cycle)
//   i_run_btn    raw run/halt button, active-low, asynchronous
//   i_step_btn   raw step button, active-low, asynchronous
//   i_bp_en      breakpoint enable
//   i_bp_addr    breakpoint PC
//   i_pc         current processor PC
//   o_cpu_en     processor clock enable (one-cycle pulses)
//   o_cpu_reset  active-high processor reset
//   o_state      0=HALT 1=RUN 2=STEP 3=RSTH
//   o_bp_hit     sticky breakpoint-hit flag
//   o_retired    count of o_cpu_en pulses (wraps)
// ---------------------------------------------------------------------------

// Per-button front end: 2-FF synchronizer followed by a debouncer.
//   btn_i    raw active-low button
//   press_o  one-cycle pulse on an accepted high-to-low level change
module cpu_run_ctrl_db #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_in,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                // Accept the new level on the DB_CYCLES-th consecutive
                // differing sample; the press pulse is raised on the same
                // edge so the FSM sees it one cycle later.
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    press_q <= level_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;
endmodule

module cpu_run_ctrl #(
    parameter int DIV_W     = 24,
    parameter int DB_CYCLES = 50000,
    parameter int RST_HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_run_btn,
    input  logic             i_step_btn,
    input  logic             i_bp_en,
    input  logic [31:0]      i_bp_addr,
    input  logic [31:0]      i_pc,
    output logic             o_cpu_en,
    output logic             o_cpu_reset,
    output logic [1:0]       o_state,
    output logic             o_bp_hit,
    output logic [31:0]      o_retired
);
    localparam int HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_RSTH = 2'd3
    } state_t;

    // Button lanes: [0] = run/halt, [1] = step.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {i_step_btn, i_run_btn};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        cpu_run_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk      (clk),
            .reset_in (reset_in),
            .btn_i    (btn_raw[g]),
            .press_o  (press[g])
        );
    end

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [HW-1:0]    hold_q;
    logic             skip_q;
    logic             en_q;
    logic             rst_q;
    logic             bp_hit_q;
    logic [31:0]      retired_q;

    logic run_evt, step_evt, tick, bp_match;

    assign run_evt  = press[0];
    assign step_evt = press[1];
    // >= keeps the period bounded if i_div is lowered mid-run.
    assign tick     = (div_q >= i_div);
    // skip_q lets a resumed run step past the breakpoint it stopped on.
    assign bp_match = i_bp_en && (i_pc == i_bp_addr) && !skip_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= S_RSTH;
            div_q     <= '0;
            hold_q    <= '0;
            skip_q    <= 1'b0;
            en_q      <= 1'b0;
            rst_q     <= 1'b1;
            bp_hit_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                S_RSTH: begin
                    // Button events are dropped while the core is held.
                    if (hold_q == HW'(RST_HOLD - 1)) begin
                        state_q <= S_HALT;
                        rst_q   <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                S_HALT: begin
                    if (run_evt) begin
                        state_q  <= S_RUN;
                        div_q    <= '0;
                        skip_q   <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end else if (step_evt) begin
                        state_q   <= S_STEP;
                        en_q      <= 1'b1;
                        retired_q <= retired_q + 32'd1;
                        bp_hit_q  <= 1'b0;
                    end
                end
                S_STEP: begin
                    state_q <= S_HALT;
                end
                S_RUN: begin
                    if (run_evt) begin
                        state_q <= S_HALT;
                    end else if (tick) begin
                        div_q <= '0;
                        if (bp_match) begin
                            bp_hit_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            en_q      <= 1'b1;
                            retired_q <= retired_q + 32'd1;
                            skip_q    <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign o_cpu_en    = en_q;
    assign o_cpu_reset = rst_q;
    assign o_state     = state_q;
    assign o_bp_hit    = bp_hit_q;
    assign o_retired   = retired_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Scoreboard bench for cpu_run_ctrl. A reference model predicts each
//   enable pulse (cycle and retired count) and pushes it into a queue; a
//   monitor at the falling edge pops and compares whenever the DUT pulses,
//   and also compares state, breakpoint flag, core reset and retired count.
//   The processor PC is emulated as 4 * o_retired.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    localparam int DIV_W    = 24;
    localparam int DB       = 4;
    localparam int RST_HOLD = 4;
    localparam int MAXC     = 40000;

    typedef enum logic [1:0] {M_HALT = 2'd0, M_RUN = 2'd1, M_STEP = 2'd2, M_HOLD = 2'd3} mmode_t;
    typedef struct {
        int          c;
        logic [31:0] r;
    } pulse_t;

    logic             clk = 1'b0;
    logic             reset_in = 1'b0;
    logic [DIV_W-1:0] i_div = '0;
    logic             i_run_btn = 1'b1;
    logic             i_step_btn = 1'b1;
    logic             i_bp_en = 1'b0;
    logic [31:0]      i_bp_addr = '0;
    logic [31:0]      i_pc;
    logic             o_cpu_en;
    logic             o_cpu_reset;
    logic [1:0]       o_state;
    logic             o_bp_hit;
    logic [31:0]      o_retired;

    cpu_run_ctrl #(.DIV_W(DIV_W), .DB_CYCLES(DB), .RST_HOLD(RST_HOLD)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .i_div      (i_div),
        .i_run_btn  (i_run_btn),
        .i_step_btn (i_step_btn),
        .i_bp_en    (i_bp_en),
        .i_bp_addr  (i_bp_addr),
        .i_pc       (i_pc),
        .o_cpu_en   (o_cpu_en),
        .o_cpu_reset(o_cpu_reset),
        .o_state    (o_state),
        .o_bp_hit   (o_bp_hit),
        .o_retired  (o_retired)
    );

    // Core stub: PC has advanced once per issued enable.
    assign i_pc = o_retired << 2;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          run_ev[MAXC];
    bit          step_ev[MAXC];
    mmode_t      m_mode = M_HOLD;
    int          m_hcnt = 0;
    bit          m_bp = 1'b0;
    bit          m_skip = 1'b0;
    int          m_next = 0;
    logic [31:0] m_retired = '0;
    pulse_t      exp_q[$];

    task automatic m_pulse(input int c);
        pulse_t p;
        m_retired = m_retired + 32'd1;
        p.c = c;
        p.r = m_retired;
        exp_q.push_back(p);
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge reset_in);
            if (!reset_in) begin
                m_mode = M_HOLD; m_hcnt = 0; m_bp = 0; m_skip = 0;
                m_retired = '0; exp_q.delete();
            end else begin
                cyc = cyc + 1;
                case (m_mode)
                    M_HOLD: begin
                        m_hcnt++;
                        if (m_hcnt == RST_HOLD) m_mode = M_HALT;
                    end
                    M_HALT: begin
                        if (run_ev[cyc]) begin
                            m_mode = M_RUN; m_bp = 0; m_skip = 1;
                            m_next = cyc + int'(i_div) + 1;
                        end else if (step_ev[cyc]) begin
                            m_mode = M_STEP; m_bp = 0;
                            m_pulse(cyc);
                        end
                    end
                    M_STEP: m_mode = M_HALT;
                    M_RUN: begin
                        if (run_ev[cyc]) begin
                            m_mode = M_HALT;
                        end else if (cyc == m_next) begin
                            m_next = cyc + int'(i_div) + 1;
                            if (i_bp_en && i_pc == i_bp_addr && !m_skip) begin
                                m_bp = 1; m_mode = M_HALT;
                            end else begin
                                m_skip = 0;
                                m_pulse(cyc);
                            end
                        end
                    end
                    default: m_mode = M_HALT;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        pulse_t p;
        bit     exp_en;
        forever begin
            @(negedge clk);
            if (reset_in) begin
                chk("state", {30'b0, o_state}, {30'b0, m_mode});
                chk("bp_hit", {31'b0, o_bp_hit}, {31'b0, m_bp});
                chk("cpu_reset", {31'b0, o_cpu_reset}, {31'b0, (m_mode == M_HOLD)});
                chk("retired", o_retired, m_retired);
                exp_en = (exp_q.size() != 0) && (exp_q[0].c == cyc);
                chk("cpu_en", {31'b0, o_cpu_en}, {31'b0, exp_en});
                if (exp_en) begin
                    p = exp_q.pop_front();
                    chk("pulse_retired", o_retired, p.r);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive buttons low for 'hold' cycles, then release and let the
    // debouncer settle back to idle.
    task automatic press(input bit run, input bit step, input int hold);
        @(negedge clk);
        if (hold >= DB) begin
            if (run)  run_ev[cyc + 3 + DB]  = 1'b1;
            if (step) step_ev[cyc + 3 + DB] = 1'b1;
        end
        if (run)  i_run_btn  = 1'b0;
        if (step) i_step_btn = 1'b0;
        repeat (hold) @(negedge clk);
        i_run_btn  = 1'b1;
        i_step_btn = 1'b1;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic stop_run(input string nm);
        for (int t = 0; t < 8; t++)
            if (o_state != 2'd0) press(1'b1, 1'b0, DB + 1);
        chk(nm, {30'b0, o_state}, 32'd0);
    endtask

    initial begin : main
        logic [31:0] r0;
        int          r;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", {30'b0, o_state}, 32'd3);
        chk("rst_cpu_reset", {31'b0, o_cpu_reset}, 32'd1);
        chk("rst_cpu_en", {31'b0, o_cpu_en}, 32'd0);
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_bp_hit", {31'b0, o_bp_hit}, 32'd0);
        reset_in = 1'b1;
        repeat (RST_HOLD + 4) @(negedge clk);
        chk("hold_done_state", {30'b0, o_state}, 32'd0);

        // Single step, then glitches that must not register.
        press(1'b0, 1'b1, 10);
        chk("step_retired", o_retired, 32'd1);
        press(1'b0, 1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 1));
            press(r[0], !r[0], int'($urandom_range(1, DB - 1)));
        end
        chk("glitch_retired", o_retired, 32'd1);

        // Run at a period of 4 cycles for at least 20 pulses.
        i_div = 3;
        press(1'b1, 1'b0, DB + 1);
        for (int k = 0; k < 300 && o_retired < 32'd21; k++) @(negedge clk);
        chk("run_20_pulses", {31'b0, (o_retired >= 32'd21)}, 32'd1);
        stop_run("run_halt");

        // Randomised runs with optional breakpoints and ignored step presses.
        for (int it = 0; it < 8; it++) begin
            i_div     = DIV_W'($urandom_range(0, 5));
            i_bp_en   = 1'($urandom_range(0, 1));
            i_bp_addr = (m_retired + 32'($urandom_range(1, 10))) << 2;
            press(1'b1, 1'b0, int'($urandom_range(DB, DB + 3)));
            repeat ($urandom_range(5, 40)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) press(1'b0, 1'b1, DB + 1);
            stop_run("rand_halt");
        end

        // Directed breakpoint: four pulses, then stop with PC on the bp.
        i_div     = 0;
        i_bp_en   = 1'b1;
        r0        = m_retired;
        i_bp_addr = (r0 + 32'd4) << 2;
        press(1'b1, 1'b0, DB + 1);
        chk("bp_state", {30'b0, o_state}, 32'd0);
        chk("bp_flag", {31'b0, o_bp_hit}, 32'd1);
        chk("bp_pc", i_pc, (r0 + 32'd4) << 2);
        chk("bp_pulses", o_retired - r0, 32'd4);
        press(1'b1, 1'b0, DB + 1);
        chk("bp_resume", {31'b0, (o_retired - r0 > 32'd4)}, 32'd1);
        chk("bp_resume_flag", {31'b0, o_bp_hit}, 32'd0);
        i_bp_en = 1'b0;
        stop_run("bp_resume_halt");

        // Simultaneous run+step, then step ignored while running.
        i_div = 1;
        press(1'b1, 1'b1, DB + 1);
        chk("simul_run", {30'b0, o_state}, 32'd1);
        press(1'b0, 1'b1, DB + 1);
        chk("step_in_run", {30'b0, o_state}, 32'd1);
        stop_run("simul_halt");

        // Retired counter wrap.
        @(negedge clk);
        #1 force dut.retired_q = 32'hFFFF_FFFF;
        m_retired = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        press(1'b0, 1'b1, DB + 1);
        chk("wrap_retired", o_retired, 32'd0);

        // Asynchronous reset in the middle of a run.
        i_div = 2;
        press(1'b1, 1'b0, DB + 1);
        repeat (7) @(negedge clk);
        #2 reset_in = 1'b0;
        #1;
        chk("async_cpu_en", {31'b0, o_cpu_en}, 32'd0);
        chk("async_state", {30'b0, o_state}, 32'd3);
        chk("async_cpu_reset", {31'b0, o_cpu_reset}, 32'd1);
        chk("async_retired", o_retired, 32'd0);
        @(negedge clk);
        reset_in = 1'b1;
        repeat (RST_HOLD + 3) @(negedge clk);
        chk("post_reset_state", {30'b0, o_state}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #(MAXC * 10);
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the KLP32V1 single-cycle core. It replaces the free-running processor clock with a one-cycle clock enable (o_cpu_en) generated from the board clk, under control of two debounced DE10-Lite push-buttons. It supports a programmable run rate, single-step, a PC breakpoint and a post-reset hold. It sits between the top level and the processor instance and drives the processor's enable and reset.

Parameters:
DIV_W, 24, width of the run-rate divider and of i_div
DB_CYCLES, 50000, consecutive stable synchronized samples required to accept a button level change (benches use 4)
RST_HOLD, 4, cycles o_cpu_reset stays high after reset_in deasserts (minimum 1)

Ports:
clk  in  1  system clock
reset_in  in  1  asynchronous active-low reset
i_div  in  DIV_W  run-mode period minus 1; 0 means an enable every cycle
i_run_btn  in  1  raw run/halt button, active-low (idle high), asynchronous
i_step_btn  in  1  raw step button, active-low, asynchronous
i_bp_en  in  1  breakpoint enable
i_bp_addr  in  32  breakpoint PC
i_pc  in  32  current processor PC (pcOut)
o_cpu_en  out  1  processor clock enable, one-cycle pulses
o_cpu_reset  out  1  active-high processor reset
o_state  out  2  0=HALT, 1=RUN, 2=STEP, 3=RSTH
o_bp_hit  out  1  sticky breakpoint-hit flag
o_retired  out  32  count of o_cpu_en pulses

Behaviour:
- Reset (reset_in low, async): state RSTH; o_cpu_en=0; o_cpu_reset=1; o_bp_hit=0; o_retired=0; divider=0; debouncers idle (released); hold counter=0.
- Button path: 2-FF synchronizer, then debouncer. The debounced level changes after the synchronized level differs from it for DB_CYCLES consecutive cycles. A press event is a one-cycle pulse on the debounced high-to-low transition. Latency from raw edge to event is 2+DB_CYCLES+1 cycles. Glitches shorter than DB_CYCLES produce no event.
- RSTH: o_cpu_reset=1 for RST_HOLD cycles after reset_in rises, then -> HALT with o_cpu_reset=0. Button events in RSTH are discarded.
- HALT: o_cpu_en=0.
  - run event -> RUN, with divider cleared and the skip_bp flag set.
  - step event -> STEP.
  - Run and step events in the same cycle -> RUN.
- STEP: o_cpu_en=1 for exactly one cycle, then -> HALT. The breakpoint is not checked in STEP. Entering STEP clears o_bp_hit.
- RUN:
  - Entering RUN clears o_bp_hit.
  - The divider increments each cycle. A tick occurs when divider >= i_div; the divider then resets to 0. Using >= keeps ticks bounded if i_div shrinks mid-run.
  - On a tick with no breakpoint match: o_cpu_en=1 that cycle and skip_bp is cleared.
  - Breakpoint match is i_bp_en && i_pc==i_bp_addr && !skip_bp. On a tick with a match, the enable is suppressed, o_bp_hit=1, and the next state is HALT. This lets RUN resume past a breakpoint it halted on.
  - A run event -> HALT, and any tick in that cycle is suppressed.
  - Step events are ignored in RUN.
- o_retired increments by 1 on every cycle o_cpu_en=1 and wraps from 0xFFFFFFFF to 0.
- All outputs are registered. o_cpu_en is never high in HALT or RSTH, and never high while o_cpu_reset=1.
- reset_in asserted mid-pulse or mid-run: all state is lost immediately, and o_cpu_en drops asynchronously.

Test Plan:
- Reset and hold: RST_HOLD=4, release reset_in -> o_cpu_reset high for exactly 4 cycles, then o_state=0, o_cpu_en=0, o_retired=0.
- Step with debounce (DB_CYCLES=4): step held low 10 cycles -> exactly one o_cpu_en pulse 7 cycles after the raw edge, o_retired=1, back to HALT. Step glitch of 3 cycles -> no pulse.
- Run rate: i_div=3, run press -> o_cpu_en pulses every 4th cycle. After 20 pulses, a run press -> HALT with o_retired=20 and no pulse in the halt cycle.
- Breakpoint: i_bp_en=1, i_bp_addr=0x10, i_pc stepping by 4 per enable from 0, i_div=0 -> 4 pulses, then halt with o_bp_hit=1 and i_pc=0x10. A second run press resumes and pulses at PC 0x10.
- Simultaneous presses: run and step events in the same HALT cycle -> o_state=1 and no STEP pulse. A step press during RUN -> no change.
- Wrap and async reset: o_retired preloaded via force to 0xFFFFFFFF, one step -> o_retired=0. Assert reset_in during RUN -> o_cpu_en=0 and o_state=3 without waiting for a clk edge.
